// File: rtl/prm_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prm_scan_pkg                                                         |
// | Shared types and helpers for the PRM obstacle-scan controller.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package prm_scan_pkg;

    localparam int CELL_IDX_W = 4;
    localparam int CNT_W      = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        OUT     = 3'd4
    } state_t;

    function automatic logic idx_in_range(input logic [CELL_IDX_W-1:0] idx,
                                          input int                    num_cells);
        return int'(idx) < num_cells;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prm_popcount.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prm_popcount                                                         |
// | Combinational population count of a W-bit vector.                    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module prm_popcount #(
    parameter int W = 16
) (
    input  logic [W-1:0]             i_bits,
    output logic [$clog2(W+1)-1:0]   o_count
);

    localparam int OUT_W = $clog2(W + 1);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            o_count = o_count + OUT_W'(i_bits[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/prm_obs_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prm_obs_scan_ctrl                                                    |
// | Builds the obstacle vector for the edge-checker bank from a stream   |
// | of cell indices, lets it settle, then returns the blocked-edge mask. |
// | Optional: PRM_SCAN_DELTA_EN adds res_delta (change vs. last result). |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module prm_obs_scan_ctrl
    import prm_scan_pkg::*;
#(
    parameter int NUM_CELLS  = 15,
    parameter int NUM_EDGES  = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cell_valid,
    output logic                  cell_ready,
    input  logic [CELL_IDX_W-1:0] cell_idx,
    input  logic                  cell_last,
    output logic [NUM_CELLS-1:0]  obs_vec,
    input  logic [NUM_EDGES-1:0]  edge_mask_in,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [NUM_EDGES-1:0]  res_mask,
    output logic [CNT_W-1:0]      res_count,
    output logic                  busy,
`ifdef PRM_SCAN_DELTA_EN
    output logic [NUM_EDGES-1:0]  res_delta,
`endif
    output logic                  err_idx
);

    localparam int C_POP_W = $clog2(NUM_EDGES + 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_settle_cnt;
    logic [NUM_CELLS-1:0]   r_obs_vec;
    logic [NUM_EDGES-1:0]   r_res_mask;
    logic [CNT_W-1:0]       r_res_count;
    logic                   r_res_valid;
    logic                   r_cell_ready;
    logic                   r_busy;
    logic                   r_err_idx;

    logic                   w_accept;
    logic                   w_idx_ok;
    logic [NUM_CELLS-1:0]   w_cell_bit;
    logic [C_POP_W-1:0]     w_pop;

    prm_popcount #(
        .W (NUM_EDGES)
    ) u_popcount (
        .i_bits  (edge_mask_in),
        .o_count (w_pop)
    );

    assign w_accept   = cell_valid && r_cell_ready &&
                        ((r_state == IDLE) || (r_state == LOAD));
    assign w_idx_ok   = idx_in_range(cell_idx, NUM_CELLS);
    // Out-of-range beats still flow through the handshake but add no bit.
    assign w_cell_bit = w_idx_ok ? (NUM_CELLS'(1) << cell_idx) : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_obs_vec    <= '0;
            r_res_mask   <= '0;
            r_res_count  <= '0;
            r_res_valid  <= 1'b0;
            r_cell_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_err_idx    <= 1'b0;
        end else begin
            if (w_accept && !w_idx_ok) begin
                r_err_idx <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_cell_ready <= 1'b1;
                    if (w_accept) begin
                        r_obs_vec <= w_cell_bit;
                        r_busy    <= 1'b1;
                        if (cell_last) begin
                            r_state      <= SETTLE;
                            r_settle_cnt <= CNT_W'(SETTLE_CYC - 1);
                            r_cell_ready <= 1'b0;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (w_accept) begin
                        r_obs_vec <= r_obs_vec | w_cell_bit;
                        if (cell_last) begin
                            r_state      <= SETTLE;
                            r_settle_cnt <= CNT_W'(SETTLE_CYC - 1);
                            r_cell_ready <= 1'b0;
                        end
                    end
                end

                SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - CNT_W'(1);
                    end
                end

                CAPTURE: begin
                    r_res_mask  <= edge_mask_in;
                    r_res_count <= CNT_W'(w_pop);
                    r_res_valid <= 1'b1;
                    r_state     <= OUT;
                end

                OUT: begin
                    if (res_ready) begin
                        r_res_valid  <= 1'b0;
                        r_busy       <= 1'b0;
                        r_cell_ready <= 1'b1;
                        r_state      <= IDLE;
                    end
                end

                default: begin
                    r_state      <= IDLE;
                    r_res_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_cell_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef PRM_SCAN_DELTA_EN
    logic [NUM_EDGES-1:0] r_prev_mask;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_prev_mask <= '0;
        end else if (r_res_valid && res_ready) begin
            r_prev_mask <= r_res_mask;
        end
    end

    assign res_delta = r_res_mask ^ r_prev_mask;
`endif

    assign cell_ready = r_cell_ready;
    assign obs_vec    = r_obs_vec;
    assign res_valid  = r_res_valid;
    assign res_mask   = r_res_mask;
    assign res_count  = r_res_count;
    assign busy       = r_busy;
    assign err_idx    = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_prm_obs_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prm_obs_scan_ctrl                                                 |
// | Table-driven, directed and random checks of prm_obs_scan_ctrl.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_prm_obs_scan_ctrl;

    localparam int NUM_CELLS  = 15;
    localparam int NUM_EDGES  = 16;
    localparam int SETTLE_CYC = 2;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic                  cell_valid = 1'b0;
    logic                  cell_ready;
    logic [3:0]            cell_idx = 4'd0;
    logic                  cell_last = 1'b0;
    logic [NUM_CELLS-1:0]  obs_vec;
    logic [NUM_EDGES-1:0]  edge_mask_in;
    logic                  res_valid;
    logic                  res_ready = 1'b0;
    logic [NUM_EDGES-1:0]  res_mask;
    logic [4:0]            res_count;
    logic                  busy;
    logic                  err_idx;
`ifdef PRM_SCAN_DELTA_EN
    logic [NUM_EDGES-1:0]  res_delta;
`endif

    int checks   = 0;
    int failures = 0;

    // Checker-bank stand-in: either a forced value or a fixed scramble of obs_vec.
    logic                  bank_sel = 1'b1;
    logic [15:0]           bank_val = 16'h0000;
    logic [15:0]           prev_model = 16'h0000;

    function automatic logic [15:0] bank_hash(input logic [14:0] v);
        return {v[3:0], v[14:4], 1'b1} ^ {1'b0, v};
    endfunction

    assign edge_mask_in = bank_sel ? bank_val : bank_hash(obs_vec);

    prm_obs_scan_ctrl #(
        .NUM_CELLS  (NUM_CELLS),
        .NUM_EDGES  (NUM_EDGES),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .cell_valid   (cell_valid),
        .cell_ready   (cell_ready),
        .cell_idx     (cell_idx),
        .cell_last    (cell_last),
        .obs_vec      (obs_vec),
        .edge_mask_in (edge_mask_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_mask     (res_mask),
        .res_count    (res_count),
        .busy         (busy),
`ifdef PRM_SCAN_DELTA_EN
        .res_delta    (res_delta),
`endif
        .err_idx      (err_idx)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one beat and hold it until the edge that accepts it.
    task automatic send_beat(input logic [3:0] idx, input logic last);
        int waitc;
        cell_valid = 1'b1;
        cell_idx   = idx;
        cell_last  = last;
        waitc      = 0;
        while (cell_ready !== 1'b1 && waitc < 40) begin
            @(posedge CLK); #1;
            waitc++;
        end
        if (waitc >= 40) check("cell_ready_timeout", 32'(cell_ready), 32'd1);
        @(posedge CLK); #1;
        cell_valid = 1'b0;
        cell_last  = 1'b0;
    endtask

    task automatic run_frame(input int n, input logic [15:0] idxs, input logic bsel,
                             input logic [15:0] bank, input logic early, input int stall,
                             input logic [14:0] e_obs, input logic [15:0] e_mask,
                             input logic [4:0] e_cnt, input logic e_err);
        int waitc;
        bank_sel  = bsel;
        bank_val  = bank;
        res_ready = early;
        for (int i = 0; i < n; i++) begin
            send_beat(idxs[i*4 +: 4], (i == n - 1));
        end
        check("cell_ready_after_last", 32'(cell_ready), 32'd0);
        check("busy_after_last", 32'(busy), 32'd1);
        repeat (SETTLE_CYC) @(posedge CLK);
        #1;
        check("res_valid_early", 32'(res_valid), 32'd0);
        check("obs_vec_settle", 32'(obs_vec), 32'(e_obs));
        // Beat cycle + SETTLE_CYC + 2 lands one edge later.
        @(posedge CLK); #1;
        check("res_valid_latency", 32'(res_valid), 32'd1);
        waitc = 0;
        while (res_valid !== 1'b1 && waitc < 20) begin
            @(posedge CLK); #1;
            waitc++;
        end
        check("res_mask", 32'(res_mask), 32'(e_mask));
        check("res_count", 32'(res_count), 32'(e_cnt));
        check("obs_vec", 32'(obs_vec), 32'(e_obs));
        check("err_idx", 32'(err_idx), 32'(e_err));
`ifdef PRM_SCAN_DELTA_EN
        check("res_delta", 32'(res_delta), 32'(e_mask ^ prev_model));
`endif
        if (!early) begin
            bank_val = ~bank;
            for (int c = 0; c < stall; c++) begin
                @(posedge CLK); #1;
                check("stall_res_valid", 32'(res_valid), 32'd1);
                check("stall_res_mask", 32'(res_mask), 32'(e_mask));
                check("stall_res_count", 32'(res_count), 32'(e_cnt));
                check("stall_cell_ready", 32'(cell_ready), 32'd0);
            end
            res_ready = 1'b1;
        end
        @(posedge CLK); #1;
        res_ready  = 1'b0;
        prev_model = e_mask;
        check("res_valid_drop", 32'(res_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("cell_ready_idle", 32'(cell_ready), 32'd1);
        check("obs_vec_retained", 32'(obs_vec), 32'(e_obs));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_obs_vec"}, 32'(obs_vec), 32'd0);
        check({tag, "_res_mask"}, 32'(res_mask), 32'd0);
        check({tag, "_res_count"}, 32'(res_count), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_cell_ready"}, 32'(cell_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err_idx"}, 32'(err_idx), 32'd0);
    endtask

    typedef struct packed {
        logic [2:0]  n;
        logic [15:0] idxs;
        logic [15:0] bank;
        logic [14:0] e_obs;
        logic [15:0] e_mask;
        logic [4:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t        tbl [5];
    int          nr;
    logic [3:0]  v;
    logic [15:0] ix;
    logic [14:0] eo;
    logic [15:0] em;
    logic        m_err;
    logic        early;

    initial begin
        // Frames run back to back; err_idx is sticky from entry 2 onward.
        tbl[0] = '{3'd3, 16'h0E30, 16'h8001, 15'h4009, 16'h8001, 5'd2,  1'b0};
        tbl[1] = '{3'd1, 16'h0007, 16'h1234, 15'h0080, 16'h1234, 5'd5,  1'b0};
        tbl[2] = '{3'd2, 16'h002F, 16'hFFFF, 15'h0004, 16'hFFFF, 5'd16, 1'b1};
        tbl[3] = '{3'd4, 16'h0955, 16'h0000, 15'h0221, 16'h0000, 5'd0,  1'b1};
        tbl[4] = '{3'd2, 16'h00DE, 16'h7FFE, 15'h6000, 16'h7FFE, 5'd14, 1'b1};

        #3;
        check_all_zero("reset");
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        for (int t = 0; t < 5; t++) begin
            run_frame(int'(tbl[t].n), tbl[t].idxs, 1'b1, tbl[t].bank, 1'b0, 0,
                      tbl[t].e_obs, tbl[t].e_mask, tbl[t].e_cnt, tbl[t].e_err);
        end

        // Long back-pressure in OUT with the bank changing underneath.
        run_frame(2, 16'h0021, 1'b1, 16'hA5A5, 1'b0, 10, 15'h0006, 16'hA5A5, 5'd8, 1'b1);

        // Reset mid-LOAD: asynchronous clear, then a clean frame.
        send_beat(4'd4, 1'b0);
        send_beat(4'd6, 1'b0);
        check("load_busy", 32'(busy), 32'd1);
        #2 RST = 1'b1;
        #1;
        check_all_zero("rst_load");
        @(posedge CLK); #1 RST = 1'b0;
        prev_model = 16'h0000;
        run_frame(1, 16'h0001, 1'b1, 16'h0300, 1'b0, 0, 15'h0002, 16'h0300, 5'd2, 1'b0);

`ifdef PRM_SCAN_DELTA_EN
        RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        prev_model = 16'h0000;
        run_frame(1, 16'h0003, 1'b1, 16'h00F0, 1'b0, 0, 15'h0008, 16'h00F0, 5'd4, 1'b0);
        check("delta_second_const", 32'(prev_model), 32'h00F0);
        bank_sel = 1'b1;
        bank_val = 16'h0F00;
        send_beat(4'd5, 1'b1);
        repeat (SETTLE_CYC + 1) @(posedge CLK);
        #1;
        check("delta_second", 32'(res_delta), 32'h0FF0);
        res_ready = 1'b1;
        @(posedge CLK); #1 res_ready = 1'b0;
        prev_model = 16'h0F00;
`endif

        // Random frames against the set-union model; early res_ready mixed in.
        m_err = err_idx === 1'b1 ? 1'b1 : 1'b0;
        m_err = 1'b0;
        for (int f = 0; f < 30; f++) begin
            nr = $urandom_range(1, 4);
            ix = 16'h0000;
            eo = 15'h0000;
            for (int i = 0; i < nr; i++) begin
                v = 4'($urandom_range(0, 15));
                ix[i*4 +: 4] = v;
                if (int'(v) < NUM_CELLS) eo = eo | (15'd1 << v);
                else m_err = 1'b1;
            end
            em    = bank_hash(eo);
            early = 1'($urandom_range(0, 1));
            run_frame(nr, ix, 1'b0, 16'h0000, early, 0, eo, em,
                      5'($countones(em)), m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
